// File: rtl/temp_display.sv
// Temperature display: converts a 13-bit signed sample (0.0625 C/LSB) into a
// 4-digit multiplexed 7-segment readout (sign/hundreds, tens, ones., tenths).
// Latency: busy for 9 cycles after din_vld; new digits on seg from the cycle after LOAD.
// Backpressure: none; din_vld is only honoured in IDLE, samples arriving while busy are dropped.
// Ports: clk, rst (sync, active-low), din[12:0], din_vld -> busy, an[3:0] (active-low), seg[7:0] (active-low, seg[7]=dp).
module temp_display #(
  parameter int MUX_DIV = 16000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] din,
  input  logic        din_vld,
  output logic        busy,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam logic [15:0] CNT_MAX = 16'(MUX_DIV - 1);

  state_t      state;
  logic        run;        // low for the first edge after reset; blocks a din_vld on the release edge
  logic        sign_q;
  logic [3:0]  tenths_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [2:0]  bit_cnt;
  logic [7:0]  dig [4];    // segment patterns per digit, already active-low
  logic [15:0] mux_cnt;
  logic [1:0]  idx;

  // Active-low segment code, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Latch-time decode: magnitude, integer/tenths split and clamping.
  logic [12:0] mag;
  logic [8:0]  int_raw;
  logic [7:0]  frac_prod;
  logic [7:0]  int_c;
  logic [3:0]  ten_c;

  always_comb begin
    mag       = din[12] ? (~din + 13'd1) : din;
    int_raw   = mag[12:4];
    frac_prod = {4'd0, mag[3:0]} * 8'd10;
    int_c     = int_raw[7:0];
    ten_c     = frac_prod[7:4];
    if (din[12] && int_raw > 9'd99) begin
      int_c = 8'd99;
      ten_c = 4'd9;
    end else if (!din[12] && int_raw > 9'd255) begin
      int_c = 8'd255;
      ten_c = 4'd9;
    end
  end

  // Shift-add-3 step: correct any BCD nibble >= 5 before the next shift.
  logic [11:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Digit patterns presented at LOAD.
  logic [3:0] h_d, t_d, o_d;

  always_comb begin
    h_d = bcd_q[11:8];
    t_d = bcd_q[7:4];
    o_d = bcd_q[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      run      <= 1'b0;
      sign_q   <= 1'b0;
      tenths_q <= 4'd0;
      bin_q    <= 8'd0;
      bcd_q    <= 12'd0;
      bit_cnt  <= 3'd0;
      for (int i = 0; i < 4; i++) dig[i] <= 8'hFF;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (din_vld && run) begin
            sign_q   <= din[12];
            tenths_q <= ten_c;
            bin_q    <= int_c;
            bcd_q    <= 12'd0;
            bit_cnt  <= 3'd0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= {bcd_adj[10:0], bin_q[7]};
          bin_q   <= {bin_q[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= LOAD;
        end
        LOAD: begin
          // All four digits change on this single edge.
          dig[3] <= sign_q ? 8'hBF : ((h_d == 4'd0) ? 8'hFF : seg7(h_d));
          dig[2] <= ((t_d == 4'd0) && (sign_q || h_d == 4'd0)) ? 8'hFF : seg7(t_d);
          dig[1] <= seg7(o_d) & 8'h7F;
          dig[0] <= seg7(tenths_q);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan; an and seg are both taken from the same idx on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mux_cnt <= 16'd0;
      idx     <= 2'd0;
      an      <= 4'b1111;
      seg     <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= dig[idx];
      if (mux_cnt == CNT_MAX) begin
        mux_cnt <= 16'd0;
        idx     <= idx + 2'd1;
      end else begin
        mux_cnt <= mux_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_temp_display.sv
// Bench for temp_display with MUX_DIV=4: directed samples, scoreboard of expected digit patterns.
// Latency: monitor checks busy width and the four digits after each completed conversion.
// Backpressure: stimulus waits for the scoreboard to drain before the next sample.
module tb_temp_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] din;
  logic        din_vld;
  logic        busy;
  logic [3:0]  an;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  temp_display #(.MUX_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .busy    (busy),
    .an      (an),
    .seg     (seg)
  );

  int total = 0;
  int bad   = 0;

  // Expected {an3, an2, an1, an0} segment bytes per accepted conversion.
  logic [31:0] sb[$];
  bit          mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [12:0] v);
    din     = v;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || mon_active) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_done: timed out with %0d pending", sb.size());
    end
  endtask

  task automatic issue(input logic [12:0] v, input logic [31:0] exp);
    sb.push_back(exp);
    pulse(v);
    wait_done();
  endtask

  // Monitor: measures busy width, then reads one full scan of the new digits.
  initial begin
    int          blen = 0;
    bit          pb   = 1'b0;
    logic [3:0]  want;
    logic [31:0] exp;
    int          n;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        blen = 0;
        pb   = 1'b0;
      end else if (busy) begin
        blen++;
        pb = 1'b1;
      end else if (pb) begin
        pb         = 1'b0;
        mon_active = 1'b1;
        check("busy_len", blen, 9);
        blen = 0;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_conv: got a conversion, expected none");
        end else begin
          exp = sb.pop_front();
          @(posedge clk);
          for (int k = 0; k < 4; k++) begin
            want = 4'b0001 << k;
            want = ~want;
            n = 0;
            do begin
              @(negedge clk);
              n++;
            end while (an !== want && n < 100);
            check($sformatf("digit%0d", k), {an, seg}, {want, exp[8*k +: 8]});
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int          errs;
    int          n;
    logic [3:0]  want;
    logic [11:0] exp_as;
    logic [7:0]  digs [4];

    rst = 1'b0; din = 13'd0; din_vld = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 8'hFF);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("release_an_seg", {an, seg}, {4'b1110, 8'hFF});
    tick();

    issue(13'h0190, {8'hFF, 8'hA4, 8'h12, 8'hC0});   // 25.0

    // Scan order and hold time with the 25.0 pattern on the digits.
    digs[0] = 8'hC0; digs[1] = 8'h12; digs[2] = 8'hA4; digs[3] = 8'hFF;
    n = 0;
    while (an == 4'b1110 && n < 50) begin @(negedge clk); n++; end
    while (an != 4'b1110 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i <= 16; i++) begin
      want   = 4'b0001 << ((i / 4) % 4);
      want   = ~want;
      exp_as = {want, digs[(i / 4) % 4]};
      check($sformatf("scan%0d", i), {an, seg}, exp_as);
      @(negedge clk);
    end
    tick();

    issue(13'h0964, {8'hF9, 8'h92, 8'h40, 8'hA4});   // 150.2
    issue(13'h1FFF, {8'hBF, 8'hFF, 8'h40, 8'hC0});   // -0.0
    issue(13'h1000, {8'hBF, 8'h90, 8'h10, 8'h90});   // clamp -99.9
    issue(13'h0FFF, {8'hA4, 8'h92, 8'h12, 8'h90});   // 255.9
    issue(13'h1F38, {8'hBF, 8'hF9, 8'h24, 8'h92});   // -12.5
    issue(13'h0690, {8'hF9, 8'hC0, 8'h12, 8'hC0});   // 105.0
    issue(13'h0000, {8'hFF, 8'hFF, 8'h40, 8'hC0});   // 0.0

    // Second sample during conversion is dropped.
    sb.push_back({8'hFF, 8'hA4, 8'h12, 8'hC0});
    pulse(13'h0190);
    tick();
    tick();
    pulse(13'h0010);
    wait_done();

    // Reset in the middle of a conversion.
    pulse(13'h0964);
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_an", an, 4'b1111);
    check("abort_seg", seg, 8'hFF);
    tick();
    tick();
    rst = 1'b1; din = 13'h0190; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    @(negedge clk);
    check("rel_vld_an_seg", {an, seg}, {4'b1110, 8'hFF});
    check("rel_vld_busy", busy, 1'b0);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seg !== 8'hFF || busy !== 1'b0) errs++;
    end
    check("blank_after_rst", errs, 0);
    tick();

    issue(13'h0010, {8'hFF, 8'hFF, 8'h79, 8'hC0});   // 1.0

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_display.md
TEMP_DISPLAY -- requirements
Module: temp_display

Interface
REQ-001 Parameter MUX_DIV, default 16000, clk cycles per displayed digit (1 kHz digit rate at 16 MHz); legal range 2..65535.
REQ-002 clk  input  1  system clock, 16 MHz; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 din  input  13  two's-complement temperature from the SPI receiver, LSB = 0.0625 C.
REQ-005 din_vld  input  1  one-cycle pulse meaning din holds a new consistent sample.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 an  output  4  digit enables, active-low; an[0] = tenths, an[1] = ones, an[2] = tens, an[3] = hundreds/sign.
REQ-008 seg  output  8  segment drive, active-low; seg[6:0] = g..a, seg[7] = decimal point.

Function
REQ-009 The FSM SHALL have three states: IDLE, CONV and LOAD.
REQ-010 IDLE with din_vld=1 SHALL latch din and go to CONV; din_vld outside IDLE SHALL be ignored, with no queuing.
REQ-011 On latch, sign = din[12] and mag = 13-bit absolute value of din.
REQ-012 Integer part int = mag[12:4]; tenths = (mag[3:0]*10)>>4, truncated, range 0..9.
REQ-013 If sign=1 and int>99, the block SHALL clamp to int=99, tenths=9 (display -99.9).
REQ-014 If sign=0 and int>255, the block SHALL clamp to 255.9.
REQ-015 CONV SHALL perform sequential shift-add-3 binary-to-BCD conversion of int[7:0], one bit per cycle, exactly 8 cycles, then go to LOAD.
REQ-016 LOAD SHALL update all four display digit registers in the same cycle, then return to IDLE; the display never shows a partially updated value.
REQ-017 busy SHALL be 1 in CONV and LOAD: 9 consecutive cycles starting the cycle after din_vld is sampled.
REQ-018 New digits SHALL appear on seg no earlier than the cycle after LOAD.
REQ-019 Digit content:
 - an[3] = '-' if sign, else the hundreds digit, blank if zero.
 - an[2] = tens digit, blank if zero and (sign or hundreds=0).
 - an[1] = ones digit with decimal point on.
 - an[0] = tenths digit.
REQ-020 Segment codes (a..g active-low) SHALL be standard for 0-9; '-' = only g lit; blank = all off; dp off on every digit except an[1].
REQ-021 The multiplex counter SHALL count 0..MUX_DIV-1 and wrap, advancing the digit index 0->1->2->3->0 on wrap.
REQ-022 Exactly one an bit SHALL be low at any time outside reset.
REQ-023 seg SHALL always correspond to the currently enabled digit, both registered on the same edge.
REQ-024 The multiplexer SHALL run independently of the FSM; conversion never stalls scanning.

Reset
REQ-025 While rst=0, the block SHALL hold:
 - FSM in IDLE, busy=0;
 - mux counter=0, digit index=0;
 - all display digits blank;
 - an=4'b1111, seg=8'hFF.
REQ-026 On the first edge after rst returns to 1, scanning SHALL start at digit 0 (an=4'b1110) with blank segments.
REQ-027 Reset during CONV or LOAD SHALL abort the conversion; display registers return to blank and no partial update occurs.
REQ-028 A din_vld coincident with the reset-release edge SHALL be ignored.

Verification
REQ-029 din=13'h0190, din_vld pulse -> busy high 9 cycles; display blank,'2','5.','0' (25.0).
REQ-030 din=13'h0964 -> '1','5','0.','2' (150.2); din=13'h1FFF -> '-',blank,'0.','0'.
REQ-031 din=13'h1000 (-256.0) -> '-','9','9.','9' (clamp); din=13'h0FFF -> '2','5','5.','9'.
REQ-032 Second din_vld (value 13'h0010) 3 cycles after first (13'h0190) -> ignored; display 25.0 and busy drops after 9 cycles.
REQ-033 MUX_DIV=4 -> an sequence 1110,1101,1011,0111,1110, each held 4 cycles; seg matches each digit.
REQ-034 rst=0 asserted in CONV cycle 4 -> busy=0, an=1111, seg=FF next edge; after release, display is blank until the next din_vld completes.
